fetch_decode: RTL and testbench
===============================

# fetch_decode

Instruction fetch and opcode pre-decode stage for the simple_cpu core. It owns the fetch PC, issues one instruction-memory request at a time over a valid/ready handshake, and captures each returned word into an IF/ID output register. Alongside that register it produces the registered one-hot opcode-class flags (ALUreg … SYSTEM) that the downstream `control` block consumes. It supports stall (hold the output) and flush/redirect (branch or jump taken).

## Interface
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC / memory address width
- RESET_PC, 0, first fetch address after reset

- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  ADDR_WIDTH  request address, word aligned
- imem_rsp_valid  in  1  response word valid (one per accepted request)
- imem_rsp_data  in  DATA_WIDTH  response instruction word
- stall  in  1  downstream not consuming; hold outputs
- flush  in  1  discard current and in-flight instruction, redirect
- redirect_pc  in  ADDR_WIDTH  new fetch address, sampled when flush=1
- valid  out  1  instr/pc/flags hold a live instruction
- instr  out  DATA_WIDTH  fetched instruction
- pc  out  ADDR_WIDTH  address of `instr`
- ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM  out  1 each  one-hot opcode class
- illegal  out  1  valid word with unrecognised opcode or instr[1:0]≠2'b11

## Operation
- FSM states: REQ, WAIT, HOLD. One request outstanding at most; one-entry HOLD buffer.
- REQ: imem_req_valid=1, imem_addr=fetch_pc held stable until ready. On ready: fetch_pc ← fetch_pc+4 (wraps mod 2^ADDR_WIDTH), go WAIT.
- WAIT: on rsp_valid, if !stall, load output register (valid=1, instr, pc, flags) and go REQ. If stall, store word+pc in HOLD buffer and go HOLD.
- HOLD: no requests. When !stall, move buffer to output and go REQ.
- Output register: when stall=1 and no flush, all outputs hold. When !stall and no new word arrives, valid ← 0 and instr/flags ← 0 (consumed).
- Decode on instr[6:0]: 0110011 ALUreg, 0010011 ALUimm, 1100011 Branch, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, 0000011 Load, 0100011 Store, 1110011 SYSTEM. All other opcodes set illegal=1 with all flags 0. All flags and illegal are 0 whenever valid=0.
- Flush has the highest priority, over stall and response:
  - valid ← 0; flags, instr and illegal ← 0.
  - fetch_pc ← {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - REQ without ready → REQ at the new address.
  - REQ with ready in the same cycle → WAIT with drop=1.
  - WAIT → WAIT with drop=1. If rsp_valid arrives in the same cycle, discard the word and go REQ.
  - HOLD → REQ, buffer discarded.
- WAIT with drop=1: the arriving response is discarded, drop ← 0, go REQ, and the output is not written.

## Timing
- Reset (rst_n=0 at an edge): state=REQ, fetch_pc=RESET_PC, drop=0, valid=0, instr=0, pc=0, all flags=0, illegal=0.
- imem_req_valid is combinational from state and is 0 while rst_n=0. The first request is visible the cycle after rst_n rises.
- Latency: request accepted at cycle N, response at N+k (k≥1), valid=1 at N+k+1.
- Best-case throughput: one instruction per 2 cycles (ready at N, rsp at N+1, next request at N+2).
- Reset asserted mid-transaction drops everything. A late response after reset is ignored because state=REQ.

## Structure
- Opcode 7-bit constants (OP_ALUREG … OP_SYSTEM) live in `defines.vh` next to the existing Imm_* constants.
- Natural sub-module: `opcode_decode`, purely combinational, instr → 10 flags + illegal, instantiated on the register input path.

## Test plan
- Reset release with RESET_PC=0x100 and ready=1, rsp 1 cycle later returning 0x00500093 → valid=1, pc=0x100, ALUimm=1; next imem_addr=0x104.
- Returned words 0x002081B3, 0x0000006F, 0x00012083, 0x00112023 → ALUreg, JAL, Load, Store respectively, exactly one flag high. Word 0x0000007F → illegal=1, all flags 0.
- stall=1 while a valid output is held and the next rsp arrives → outputs unchanged, FSM enters HOLD, no imem_req_valid. stall=0 → buffered word appears next cycle.
- flush in WAIT with redirect_pc=0x203, rsp arriving 2 cycles later → that word is discarded, valid stays 0, next imem_addr=0x200.
- flush and rsp_valid in the same cycle, and flush+stall together → valid=0 next cycle, new request at the redirect address, flush wins.
- fetch_pc=0xFFFFFFFC accepted → next imem_addr=0x00000000. rst_n=0 during WAIT → all outputs return to their reset values.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: shared fetch FSM states, RV32 opcode constants and the opcode-class record
// Contents: state_t (REQ/WAIT/HOLD), OP_* 7-bit opcodes, class_t (ten one-hot flags + illegal)
package fetch_decode_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef struct packed {
    logic alu_reg;
    logic alu_imm;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic load;
    logic store;
    logic system;
    logic illegal;
  } class_t;
endpackage

// File: rtl/fetch_decode_if.sv
// fetch_decode_if: instruction-memory request/response handshake
// master (fetch side): drives req_valid, addr; samples req_ready, rsp_valid, rsp_data
// slave (memory side): the mirror image
interface fetch_decode_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
  modport slave (input req_valid, addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_decode_opcode_decode.sv
// fetch_decode_opcode_decode: combinational opcode pre-decode into one-hot class flags
// opcode in: instr[6:0]; cls out: ten class flags, illegal set when no class matches
module fetch_decode_opcode_decode import fetch_decode_pkg::*; (
  input  logic [6:0] opcode,
  output class_t     cls
);
  logic [9:0] hit;
  assign hit = {opcode == OP_ALUREG, opcode == OP_ALUIMM, opcode == OP_BRANCH, opcode == OP_JAL,
                opcode == OP_JALR, opcode == OP_LUI, opcode == OP_AUIPC, opcode == OP_LOAD,
                opcode == OP_STORE, opcode == OP_SYSTEM};
  assign cls = {hit, ~|hit};
endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch FSM with one outstanding request, hold buffer and IF/ID register
// clk, rst_n (sync, active low); imem: request/response bus (master side)
// stall holds outputs; flush + redirect_pc drop in-flight work and refetch
// valid/instr/pc/class flags/illegal: registered IF/ID outputs
module fetch_decode import fetch_decode_pkg::*; #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_decode_if.master        imem,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  ALUreg,
  output logic                  ALUimm,
  output logic                  Branch,
  output logic                  JAL,
  output logic                  JALR,
  output logic                  LUI,
  output logic                  AUIPC,
  output logic                  Load,
  output logic                  Store,
  output logic                  SYSTEM,
  output logic                  illegal
);
  state_t                state;
  logic                  drop;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] hold_pc;
  logic [DATA_WIDTH-1:0] hold_instr;
  class_t                cls;
  class_t                nxt_cls;
  logic                  load;
  logic                  keep_wait;
  logic [DATA_WIDTH-1:0] load_word;
  logic [ADDR_WIDTH-1:0] load_pc;
  assign imem.req_valid = rst_n && state == REQ;
  assign imem.addr = fetch_pc;
  assign load = !stall && ((state == WAIT && imem.rsp_valid && !drop) || state == HOLD);
  assign load_word = state == HOLD ? hold_instr : imem.rsp_data;
  assign load_pc = state == HOLD ? hold_pc : req_pc;
  // a flush leaves us waiting only when a request is (or just became) outstanding with no response yet
  assign keep_wait = (state == REQ && imem.req_ready) || (state == WAIT && !imem.rsp_valid);
  fetch_decode_opcode_decode u_dec (
    .opcode(load_word[6:0]),
    .cls   (nxt_cls)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= REQ;
      drop <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      hold_pc <= '0;
      hold_instr <= '0;
      valid <= 1'b0;
      instr <= '0;
      pc <= '0;
      cls <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= '0;
      cls <= '0;
      fetch_pc <= redirect_pc & ~ADDR_WIDTH'(3);
      drop <= keep_wait;
      state <= keep_wait ? WAIT : REQ;
    end else begin
      if (!stall) begin
        valid <= load;
        instr <= load ? load_word : '0;
        cls <= load ? nxt_cls : '0;
      end
      if (load) pc <= load_pc;
      if (state == REQ && imem.req_ready) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        req_pc <= fetch_pc;
        state <= WAIT;
      end
      if (state == WAIT && imem.rsp_valid) begin
        drop <= 1'b0;
        hold_instr <= imem.rsp_data;
        hold_pc <= req_pc;
        state <= (stall && !drop) ? HOLD : REQ;
      end
      if (state == HOLD && !stall) state <= REQ;
    end
  end
  assign ALUreg = cls.alu_reg;
  assign ALUimm = cls.alu_imm;
  assign Branch = cls.branch;
  assign JAL = cls.jal;
  assign JALR = cls.jalr;
  assign LUI = cls.lui;
  assign AUIPC = cls.auipc;
  assign Load = cls.load;
  assign Store = cls.store;
  assign SYSTEM = cls.system;
  assign illegal = cls.illegal;
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed and randomized checks of fetch_decode against a stream-level reference model
module tb_fetch_decode;
  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic [31:0] redirect_pc;
  logic        valid;
  logic [31:0] instr, pc;
  logic        ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM, illegal;
  logic [10:0] cls_obs;
  int          total = 0;
  int          passed = 0;
  logic [6:0]  cls_op [10];
  logic [6:0]  op_tab [12];
  always #5 clk = ~clk;
  fetch_decode_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) imem ();
  fetch_decode #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .valid(valid), .instr(instr), .pc(pc), .ALUreg(ALUreg), .ALUimm(ALUimm), .Branch(Branch),
    .JAL(JAL), .JALR(JALR), .LUI(LUI), .AUIPC(AUIPC), .Load(Load), .Store(Store), .SYSTEM(SYSTEM),
    .illegal(illegal)
  );
  assign cls_obs = {ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM, illegal};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  // class flags straight from the opcode table: one bit per matching class, illegal if none
  function automatic logic [10:0] ref_cls(input logic [31:0] w);
    logic [10:0] r = '0;
    for (int i = 0; i < 10; i++) if (w[6:0] == cls_op[i]) r[10-i] = 1'b1;
    if (r == '0) r[0] = 1'b1;
    return r;
  endfunction
  // memory contents: a hash of the address picks a body and an opcode (legal and illegal mixed)
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] h = a * 32'h9E3779B1;
    int idx = int'(h[31:28]) % 12;
    return {h[24:0], op_tab[idx]};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_out(input string tag, input logic ev, input logic [31:0] ew, input logic [31:0] ep);
    chk({tag, "_valid"}, valid, ev);
    chk({tag, "_instr"}, instr, ev ? ew : 32'h0);
    chk({tag, "_cls"}, cls_obs, ev ? ref_cls(ew) : 11'h0);
    if (ev) chk({tag, "_pc"}, pc, ep);
  endtask
  task automatic fetch(input logic [31:0] w, input int k);
    imem.req_ready = 1'b1;
    tick;
    imem.req_ready = 1'b0;
    repeat (k - 1) tick;
    imem.rsp_valid = 1'b1;
    imem.rsp_data = w;
    tick;
    imem.rsp_valid = 1'b0;
  endtask
  initial begin
    logic [31:0] words [6];
    logic [31:0] exp_pc, exp_req, pend_addr, acc_addr, rd, pi, ppc;
    logic [10:0] pcls;
    logic        pend, acc, f, st, pv;
    int          lat, delivered;
    cls_op = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111,
               7'b0110111, 7'b0010111, 7'b0000011, 7'b0100011, 7'b1110011};
    for (int i = 0; i < 10; i++) op_tab[i] = cls_op[i];
    op_tab[10] = 7'h7F;
    op_tab[11] = 7'b0110001;
    words = '{32'h002081B3, 32'h0000006F, 32'h00012083, 32'h00112023, 32'h00000063, 32'h0000007F};
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    imem.req_ready = 1'b0; imem.rsp_valid = 1'b0; imem.rsp_data = '0;
    tick;
    tick;
    check_out("rst", 1'b0, 0, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_reqv", imem.req_valid, 1'b0);
    rst_n = 1'b1;
    imem.req_ready = 1'b1;
    #1;
    chk("first_reqv", imem.req_valid, 1'b1);
    chk("first_addr", imem.addr, 32'h100);
    tick;
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b1;
    imem.rsp_data = 32'h00500093;
    tick;
    imem.rsp_valid = 1'b0;
    check_out("first", 1'b1, 32'h00500093, 32'h100);
    chk("first_aluimm", ALUimm, 1'b1);
    chk("next_addr", imem.addr, 32'h104);
    exp_pc = 32'h104;
    for (int i = 0; i < 6; i++) begin
      fetch(words[i], 1 + i % 2);
      check_out($sformatf("dec%0d", i), 1'b1, words[i], exp_pc);
      exp_pc += 4;
    end
    chk("illegal_flag", illegal, 1'b1);
    stall = 1'b1;
    imem.req_ready = 1'b1;
    tick;
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b1;
    imem.rsp_data = 32'h00A00513;
    tick;
    imem.rsp_valid = 1'b0;
    check_out("stall_hold", 1'b1, 32'h0000007F, exp_pc - 4);
    chk("hold_noreq", imem.req_valid, 1'b0);
    tick;
    check_out("stall_hold2", 1'b1, 32'h0000007F, exp_pc - 4);
    chk("hold_noreq2", imem.req_valid, 1'b0);
    stall = 1'b0;
    tick;
    check_out("unhold", 1'b1, 32'h00A00513, exp_pc);
    exp_pc += 4;
    chk("unhold_reqv", imem.req_valid, 1'b1);
    chk("unhold_addr", imem.addr, exp_pc);
    tick;
    check_out("consumed", 1'b0, 0, 0);
    imem.req_ready = 1'b1;
    tick;
    imem.req_ready = 1'b0;
    flush = 1'b1;
    redirect_pc = 32'h203;
    tick;
    flush = 1'b0;
    tick;
    imem.rsp_valid = 1'b1;
    imem.rsp_data = 32'h00112023;
    tick;
    imem.rsp_valid = 1'b0;
    check_out("flush_wait", 1'b0, 0, 0);
    chk("flush_wait_reqv", imem.req_valid, 1'b1);
    chk("flush_wait_addr", imem.addr, 32'h200);
    fetch(32'h0000006F, 1);
    check_out("redir_word", 1'b1, 32'h0000006F, 32'h200);
    stall = 1'b1;
    flush = 1'b1;
    redirect_pc = 32'h404;
    tick;
    flush = 1'b0;
    stall = 1'b0;
    check_out("flush_stall", 1'b0, 0, 0);
    chk("flush_stall_reqv", imem.req_valid, 1'b1);
    chk("flush_stall_addr", imem.addr, 32'h404);
    imem.req_ready = 1'b1;
    tick;
    imem.req_ready = 1'b0;
    flush = 1'b1;
    redirect_pc = 32'h500;
    imem.rsp_valid = 1'b1;
    imem.rsp_data = 32'h00500093;
    tick;
    flush = 1'b0;
    imem.rsp_valid = 1'b0;
    check_out("flush_rsp", 1'b0, 0, 0);
    chk("flush_rsp_reqv", imem.req_valid, 1'b1);
    chk("flush_rsp_addr", imem.addr, 32'h500);
    flush = 1'b1;
    redirect_pc = 32'hFFFFFFFF;
    tick;
    flush = 1'b0;
    chk("wrap_start", imem.addr, 32'hFFFFFFFC);
    fetch(32'h00012083, 1);
    check_out("wrap", 1'b1, 32'h00012083, 32'hFFFFFFFC);
    chk("wrap_addr", imem.addr, 32'h0);
    stall = 1'b1;
    imem.req_ready = 1'b1;
    tick;
    imem.req_ready = 1'b0;
    chk("pre_rst_valid", valid, 1'b1);
    rst_n = 1'b0;
    tick;
    check_out("rst_wait", 1'b0, 0, 0);
    chk("rst_wait_pc", pc, 32'h0);
    chk("rst_wait_reqv", imem.req_valid, 1'b0);
    rst_n = 1'b1;
    stall = 1'b0;
    imem.rsp_valid = 1'b1;
    imem.rsp_data = 32'h00112023;
    tick;
    imem.rsp_valid = 1'b0;
    check_out("late_rsp", 1'b0, 0, 0);
    chk("late_rsp_reqv", imem.req_valid, 1'b1);
    chk("late_rsp_addr", imem.addr, 32'h100);
    // random phase: memory with 1..3 cycle latency, random ready/stall/flush
    exp_pc = 32'h100;
    exp_req = 32'h100;
    pend = 1'b0;
    pend_addr = '0;
    lat = 0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      imem.req_ready = $urandom_range(1, 0) == 1;
      stall = $urandom_range(9, 0) < 3;
      flush = $urandom_range(24, 0) == 0;
      redirect_pc = $urandom & 32'h0000FFFF;
      imem.rsp_valid = pend && lat == 0;
      imem.rsp_data = mem(pend_addr);
      acc = imem.req_valid && imem.req_ready;
      acc_addr = imem.addr;
      if (acc) begin
        chk("one_outstanding", pend, 1'b0);
        chk("req_addr", acc_addr, exp_req);
      end
      f = flush;
      st = stall;
      rd = redirect_pc;
      pv = valid;
      pi = instr;
      ppc = pc;
      pcls = cls_obs;
      tick;
      if (imem.rsp_valid) pend = 1'b0;
      else if (pend) lat--;
      if (acc) begin
        pend = 1'b1;
        pend_addr = acc_addr;
        lat = $urandom_range(2, 0);
        exp_req += 4;
      end
      if (f) begin
        exp_req = rd & ~32'h3;
        exp_pc = rd & ~32'h3;
        chk("r_flush_valid", {valid, instr, cls_obs}, '0);
      end else if (st) begin
        chk("r_hold", {valid, instr, cls_obs}, {pv, pi, pcls});
        if (pv) chk("r_hold_pc", pc, ppc);
      end else if (valid) begin
        chk("r_pc", pc, exp_pc);
        chk("r_instr", instr, mem(exp_pc));
        chk("r_cls", cls_obs, ref_cls(mem(exp_pc)));
        exp_pc += 4;
        delivered++;
      end else begin
        chk("r_idle", {instr, cls_obs}, '0);
      end
    end
    chk("r_delivered", delivered > 100, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
